// File: rtl/int_req_latch_pkg.sv
// Shared definitions for the interrupt request latch: FSM encoding and default vectors.
package int_req_latch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        SVC  = 2'b10
    } state_t;

    localparam logic [15:0] DEF_NMI_VEC = 16'hFFFA;
    localparam logic [15:0] DEF_IRQ_VEC = 16'hFFFE;

endpackage

// File: rtl/int_req_latch_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up on inc, stick at all ones, clear or reset to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/int_req_latch.sv
// Latches the NMI pulse, merges it with the masked IRQ level, raises one
// prioritized request to the core and tracks the ack/done service window.
module int_req_latch
    import int_req_latch_pkg::*;
#(
    parameter logic [15:0] NMI_VEC = DEF_NMI_VEC,
    parameter logic [15:0] IRQ_VEC = DEF_IRQ_VEC,
    parameter int          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nmi_pls,
    input  logic             irq_n,
    input  logic             irq_msk,
    input  logic             int_ack,
    input  logic             int_done,
    input  logic             lost_clr,
    output logic             int_req,
    output logic             int_nmi,
    output logic [15:0]      vec,
    output logic             spur,
    output logic [CNT_W-1:0] lost_cnt
);

    state_t state, state_nxt;
    logic   nmi_pend;
    logic   svc_nmi;
    logic   irq_act;
    logic   any_src;
    logic   take;
    logic   nmi_clr;
    logic   lost_inc;

    assign irq_act  = ~irq_n & ~irq_msk;
    assign any_src  = nmi_pend | irq_act;
    // An ack only counts while a request is actually outstanding.
    assign take     = (state == REQ) & int_ack;
    assign nmi_clr  = take & nmi_pend;
    // A pulse arriving while the old NMI is consumed this cycle is not lost.
    assign lost_inc = nmi_pls & nmi_pend & ~nmi_clr;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and request outputs; NMI wins selection while requesting.
    always_comb begin
        state_nxt = state;
        int_req   = 1'b0;
        int_nmi   = 1'b0;
        case (state)
            IDLE: begin
                if (any_src) state_nxt = REQ;
            end
            REQ: begin
                int_req = 1'b1;
                int_nmi = nmi_pend;
                if (int_ack) begin
                    state_nxt = SVC;
                end else if (!any_src) begin
                    state_nxt = IDLE;
                end
            end
            SVC: begin
                int_nmi = svc_nmi;
                if (int_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NMI pending flag; a new pulse survives a coincident clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            nmi_pend <= 1'b0;
        end else begin
            nmi_pend <= nmi_pls | (nmi_pend & ~nmi_clr);
        end
    end

    // Capture the serviced source at ack; spur flags an ack with nothing to serve.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vec     <= IRQ_VEC;
            svc_nmi <= 1'b0;
            spur    <= 1'b0;
        end else begin
            spur <= take & ~any_src;
            if (take) begin
                vec     <= nmi_pend ? NMI_VEC : IRQ_VEC;
                svc_nmi <= nmi_pend;
            end
        end
    end

    sat_cnt #(.W(CNT_W)) u_lost (
        .clk (clk),
        .rst (rst),
        .inc (lost_inc),
        .clr (lost_clr),
        .cnt (lost_cnt)
    );

endmodule

// File: tb/tb_int_req_latch.sv
// Scoreboard bench: the driver runs a behavioural model and queues expected
// outputs; the monitor pops and compares after each rising edge.
module tb_int_req_latch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic nmi_pls = 1'b0, irq_n = 1'b1, irq_msk = 1'b0;
    logic int_ack = 1'b0, int_done = 1'b0, lost_clr = 1'b0;

    logic        req_a, nmi_a, spur_a;
    logic [15:0] vec_a;
    logic [7:0]  lost_a;
    logic        req_b, nmi_b, spur_b;
    logic [15:0] vec_b;
    logic [1:0]  lost_b;

    always #5 clk = ~clk;

    int_req_latch u_dut (
        .clk(clk), .rst(rst), .nmi_pls(nmi_pls), .irq_n(irq_n), .irq_msk(irq_msk),
        .int_ack(int_ack), .int_done(int_done), .lost_clr(lost_clr),
        .int_req(req_a), .int_nmi(nmi_a), .vec(vec_a), .spur(spur_a), .lost_cnt(lost_a)
    );

    int_req_latch #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .nmi_pls(nmi_pls), .irq_n(irq_n), .irq_msk(irq_msk),
        .int_ack(int_ack), .int_done(int_done), .lost_clr(lost_clr),
        .int_req(req_b), .int_nmi(nmi_b), .vec(vec_b), .spur(spur_b), .lost_cnt(lost_b)
    );

    typedef struct {
        bit          req;
        bit          nmi;
        bit          spur;
        logic [15:0] vec;
        int          l8;
        int          l2;
    } exp_t;

    typedef struct {
        logic [15:0] vec;
        bit          nmi;
        bit          spur;
    } svc_t;

    exp_t expq[$];
    svc_t svcq[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: abstract flags, lost count kept unbounded and clipped on compare.
    bit          m_pend, m_asking, m_serving, m_svcnmi, m_spur;
    logic [15:0] m_vec;
    int          m_lost;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clip(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step(input bit nmi, input bit irqn, input bit msk, input bit ack,
                              input bit done, input bit clr, input bit rs);
        bit   src, take, used;
        bit   n_ask, n_srv;
        svc_t s;
        exp_t e;
        if (!rs) begin
            m_pend = 0; m_asking = 0; m_serving = 0; m_svcnmi = 0; m_spur = 0;
            m_vec = 16'hFFFE; m_lost = 0;
        end else begin
            src  = m_pend || (!irqn && !msk);
            take = m_asking && ack;
            used = take && m_pend;
            if (nmi && m_pend && !used) m_lost++;
            if (clr) m_lost = 0;
            m_spur = take && !src;
            if (take) begin
                m_vec    = m_pend ? 16'hFFFA : 16'hFFFE;
                m_svcnmi = m_pend;
                s.vec = m_vec; s.nmi = m_svcnmi; s.spur = m_spur;
                svcq.push_back(s);
            end
            n_ask = m_asking; n_srv = m_serving;
            if (m_asking) begin
                if (ack) begin n_ask = 0; n_srv = 1; end
                else if (!src) n_ask = 0;
            end else if (m_serving) begin
                if (done) n_srv = 0;
            end else if (src) begin
                n_ask = 1;
            end
            m_asking = n_ask; m_serving = n_srv;
            m_pend = nmi || (m_pend && !used);
        end
        e.req  = m_asking;
        e.nmi  = m_asking ? m_pend : (m_serving ? m_svcnmi : 1'b0);
        e.spur = m_spur;
        e.vec  = m_vec;
        e.l8   = clip(m_lost, 255);
        e.l2   = clip(m_lost, 3);
        expq.push_back(e);
    endtask

    // Drive one cycle of inputs away from the rising edge and queue its expectation.
    task automatic cyc(input bit nmi, input bit irqn, input bit msk, input bit ack,
                       input bit done, input bit clr, input bit rs);
        @(negedge clk);
        nmi_pls = nmi; irq_n = irqn; irq_msk = msk;
        int_ack = ack; int_done = done; lost_clr = clr; rst = rs;
        model_step(nmi, irqn, msk, ack, done, clr, rs);
    endtask

    // Monitor: compare every cycle, and pop a service record when the DUT takes an ack.
    bit prev_req = 0;
    initial begin
        exp_t e;
        svc_t s;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("int_req",    int'(req_a),  int'(e.req));
                chk("int_nmi",    int'(nmi_a),  int'(e.nmi));
                chk("spur",       int'(spur_a), int'(e.spur));
                chk("vec",        int'(vec_a),  int'(e.vec));
                chk("lost_cnt",   int'(lost_a), e.l8);
                chk("lost_cnt_w2", int'(lost_b), e.l2);
                chk("int_req_w2", int'(req_b),  int'(e.req));
                chk("vec_w2",     int'(vec_b),  int'(e.vec));
                chk("nmi_w2",     int'(nmi_b),  int'(e.nmi));
                chk("spur_w2",    int'(spur_b), int'(e.spur));
                if (rst && prev_req && int_ack) begin
                    if (svcq.size() == 0) begin
                        chk("svc_unexpected", 1, 0);
                    end else begin
                        s = svcq.pop_front();
                        chk("svc_vec",  int'(vec_a),  int'(s.vec));
                        chk("svc_nmi",  int'(nmi_a),  int'(s.nmi));
                        chk("svc_spur", int'(spur_a), int'(s.spur));
                    end
                end
                prev_req = req_a;
            end
        end
    end

    initial begin
        // reset held with active sources
        cyc(1,0,0,0,0,0,0); cyc(1,0,0,0,0,0,0);
        repeat (3) cyc(0,1,0,0,0,0,1);
        // NMI basic
        cyc(1,1,0,0,0,0,1);
        repeat (3) cyc(0,1,0,0,0,0,1);
        cyc(0,1,0,1,0,0,1); cyc(0,1,0,0,0,0,1); cyc(0,1,0,0,1,0,1);
        repeat (2) cyc(0,1,0,0,0,0,1);
        // priority: NMI and IRQ together
        cyc(1,0,0,0,0,0,1);
        repeat (2) cyc(0,0,0,0,0,0,1);
        cyc(0,0,0,1,0,0,1); cyc(0,0,0,0,1,0,1);
        repeat (2) cyc(0,0,0,0,0,0,1);
        cyc(0,0,0,1,0,0,1); cyc(0,0,0,0,1,0,1);
        repeat (2) cyc(0,1,0,0,0,0,1);
        // mask withdraws IRQ request
        repeat (3) cyc(0,0,0,0,0,0,1);
        repeat (2) cyc(0,0,1,0,0,0,1);
        cyc(0,1,0,0,0,0,1);
        // lost count, then set-wins on ack
        cyc(1,1,0,0,0,0,1); cyc(0,1,0,0,0,0,1);
        repeat (3) cyc(1,1,0,0,0,0,1);
        cyc(1,1,0,1,0,0,1); cyc(0,1,0,0,0,0,1); cyc(0,1,0,0,1,0,1);
        repeat (2) cyc(0,1,0,0,0,0,1);
        cyc(0,1,0,1,0,0,1); cyc(0,1,0,0,1,0,1);
        // saturation of the narrow counter, then clear
        cyc(1,1,0,0,0,0,1);
        repeat (5) cyc(1,1,0,0,0,0,1);
        cyc(0,1,0,0,0,1,1);
        cyc(0,1,0,1,0,0,1); cyc(0,1,0,0,1,0,1);
        repeat (2) cyc(0,1,0,0,0,0,1);
        // spurious: ack on the cycle IRQ drops
        repeat (3) cyc(0,0,0,0,0,0,1);
        cyc(0,1,0,1,0,0,1); cyc(0,1,0,0,0,0,1); cyc(0,1,0,0,1,0,1);
        cyc(0,1,0,0,0,0,1);
        // reset during service
        repeat (3) cyc(0,0,0,0,0,0,1);
        cyc(0,0,0,1,0,0,1); cyc(1,0,0,0,0,0,1);
        cyc(0,0,0,0,0,0,0);
        repeat (2) cyc(0,1,0,0,0,0,1);
        // randomized traffic
        begin
            bit irqn_r = 1, msk_r = 0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 5) == 0) irqn_r = ~irqn_r;
                if ($urandom_range(0, 15) == 0) msk_r = ~msk_r;
                cyc(($urandom_range(0, 6) == 0), irqn_r, msk_r,
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 40) == 0), ($urandom_range(0, 150) != 0));
            end
        end
        cyc(0,1,0,0,0,0,1);
        repeat (3) @(posedge clk);
        #2;
        chk("expq_drained", expq.size(), 0);
        chk("svcq_drained", svcq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
